// File: rtl/jtbubl_snd_out_if.sv
// Sound-path bus between the game core and the output conditioning stage.
interface jtbubl_snd_out_if #(
   parameter int unsigned W = 16
);
   logic signed [W-1:0] snd_in;
   logic                sample_in;
   logic [1:0]          fxlevel;
   logic                mute;
   logic signed [W-1:0] snd_out;
   logic                sample_out;
   logic                clip;
   logic                muted;

   modport master (
      output snd_in, sample_in, fxlevel, mute,
      input  snd_out, sample_out, clip, muted
   );

   modport slave (
      input  snd_in, sample_in, fxlevel, mute,
      output snd_out, sample_out, clip, muted
   );
endinterface

// File: rtl/jtbubl_snd_out.sv
// Audio output conditioning: gain, optional DC blocker, mute fade, saturation.
// Define JTBUBL_DCBLOCK_EN to build the DC blocker into stage 2.
module jtbubl_snd_out #(
   parameter int unsigned W      = 16,
   parameter int unsigned FADE_W = 8,
   parameter int unsigned DC_SH  = 8
)(
   input  logic            clk,
   input  logic            rst_n,
   jtbubl_snd_out_if.slave io
);
   localparam int unsigned GW  = W + 2;
   localparam int unsigned YW  = W + 4;
   localparam int unsigned FW  = FADE_W + 2;
   localparam int unsigned PW  = YW + FW;
   localparam int unsigned FQW = PW - FADE_W;

   localparam logic [FADE_W:0]         FADE_FULL = {1'b1, {FADE_W{1'b0}}};
   localparam logic signed [FQW-1:0]   SAT_HI    = FQW'((1 << (W - 1)) - 1);
   localparam logic signed [FQW-1:0]   SAT_LO    = ~SAT_HI;

   if (DC_SH >= YW) begin : g_bad_dc_sh
      $error("DC_SH must be smaller than the DC accumulator width");
   end

   typedef enum logic [1:0] {MUTED, RAMP_UP, PLAY, RAMP_DOWN} state_t;

   state_t                state_q, state_d;
   logic [FADE_W:0]       fade_q, fade_d;
   logic                  sample_l_q, sample_l_d;
   logic                  new_q, new_d;
   logic                  v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic signed [GW-1:0]  g1_q, g1_d;
   logic [FADE_W:0]       fade1_q, fade1_d, fade2_q, fade2_d;
   logic signed [YW-1:0]  y2_q, y2_d;
   logic signed [FQW-1:0] f3_q, f3_d;
   logic signed [W-1:0]   snd_out_q, snd_out_d;
   logic                  sample_out_q, sample_out_d;
   logic                  clip_q, clip_d;
   logic                  muted_q, muted_d;

   logic signed [GW-1:0]  x, g;
   logic signed [YW-1:0]  g_ext, y_c;
   logic signed [FW-1:0]  fade_s;
`ifdef JTBUBL_DCBLOCK_EN
   logic signed [YW-1:0]  gprev_q, gprev_d, yprev_q, yprev_d;
`endif

   always_comb begin
      sample_l_d = io.sample_in;
      new_d      = io.sample_in & ~sample_l_q;

      // Fade FSM steps once per accepted sample; transitions use the stepped fade
      state_d = state_q;
      fade_d  = fade_q;
      if (new_q) begin
         if (state_q == MUTED) begin
            if (!io.mute) begin
               fade_d  = (FADE_W+1)'(1);
               state_d = RAMP_UP;
            end
         end else if (io.mute) begin
            fade_d  = fade_q - (FADE_W+1)'(1);
            state_d = (fade_d == '0) ? MUTED : RAMP_DOWN;
         end else begin
            if (state_q != PLAY) fade_d = fade_q + (FADE_W+1)'(1);
            state_d = (fade_d == FADE_FULL) ? PLAY : RAMP_UP;
         end
      end
      muted_d = (state_d == MUTED);

      x = {{2{io.snd_in[W-1]}}, io.snd_in};
      case (io.fxlevel)
         2'b00:   g = x >>> 1;
         2'b01:   g = x;
         2'b10:   g = x + (x >>> 1);
         default: g = x <<< 1;
      endcase
      v1_d    = new_q;
      g1_d    = g;
      fade1_d = fade_d;

      g_ext = {{(YW-GW){g1_q[GW-1]}}, g1_q};
`ifdef JTBUBL_DCBLOCK_EN
      y_c     = g_ext - gprev_q + yprev_q - (yprev_q >>> DC_SH);
      gprev_d = v1_q ? g_ext : gprev_q;
      yprev_d = v1_q ? y_c   : yprev_q;
`else
      y_c     = g_ext;
`endif
      v2_d    = v1_q;
      y2_d    = y_c;
      fade2_d = fade1_q;

      fade_s = {1'b0, fade2_q};
      v3_d   = v2_q;
      f3_d   = FQW'((PW'(y2_q) * PW'(fade_s)) >>> FADE_W);

      sample_out_d = v3_q;
      clip_d       = 1'b0;
      snd_out_d    = snd_out_q;
      if (v3_q) begin
         if (f3_q > SAT_HI) begin
            snd_out_d = W'(SAT_HI);
            clip_d    = 1'b1;
         end else if (f3_q < SAT_LO) begin
            snd_out_d = W'(SAT_LO);
            clip_d    = 1'b1;
         end else begin
            snd_out_d = W'(f3_q);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= MUTED;
         fade_q       <= '0;
         sample_l_q   <= 1'b0;
         new_q        <= 1'b0;
         v1_q         <= 1'b0;
         v2_q         <= 1'b0;
         v3_q         <= 1'b0;
         g1_q         <= '0;
         fade1_q      <= '0;
         fade2_q      <= '0;
         y2_q         <= '0;
         f3_q         <= '0;
         snd_out_q    <= '0;
         sample_out_q <= 1'b0;
         clip_q       <= 1'b0;
         muted_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         fade_q       <= fade_d;
         sample_l_q   <= sample_l_d;
         new_q        <= new_d;
         v1_q         <= v1_d;
         v2_q         <= v2_d;
         v3_q         <= v3_d;
         g1_q         <= g1_d;
         fade1_q      <= fade1_d;
         fade2_q      <= fade2_d;
         y2_q         <= y2_d;
         f3_q         <= f3_d;
         snd_out_q    <= snd_out_d;
         sample_out_q <= sample_out_d;
         clip_q       <= clip_d;
         muted_q      <= muted_d;
      end
   end

`ifdef JTBUBL_DCBLOCK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gprev_q <= '0;
         yprev_q <= '0;
      end else begin
         gprev_q <= gprev_d;
         yprev_q <= yprev_d;
      end
   end
`endif

   assign io.snd_out    = snd_out_q;
   assign io.sample_out = sample_out_q;
   assign io.clip       = clip_q;
   assign io.muted      = muted_q;
endmodule
